// File: rtl/regload_arbiter_pkg.sv
// Shared definitions for the register-load arbiter.
// Holds the FSM state encoding and a constant-width helper used to size
// the round-robin pointer and the latched winner index.
package regload_arbiter_pkg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_ACK  = 2'b10;

  // Ceiling log2 with a floor of 1 bit, so a single requester still gets
  // a legal one-bit index.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regload_arbiter_rr_pick.sv
// Combinational round-robin picker: scans req from ptr upward, wrapping at NREQ.
// Latency: zero (pure combinational). Backpressure: none; the caller decides when to use it.
// Ports: req_i (request levels), ptr_i (highest-priority index),
//        win_o (winning index), vld_o (at least one request present).
module rr_pick
  import regload_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [PW-1:0]   win_o,
  output logic            vld_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    win_o = '0;
    vld_o = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      // ptr_i < NREQ, so a single conditional subtract performs the modulo.
      sum = {1'b0, ptr_i} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = sum[PW-1:0];
      if (!vld_o && req_i[idx]) begin
        vld_o = 1'b1;
        win_o = idx;
      end
    end
  end

endmodule

// File: rtl/regload_arbiter.sv
// Round-robin sequencer sharing one load bus among NREQ requesters; drives active-low
// register enables, one load per grant. Latency: request edge t -> register loaded at t+1
// -> ack during t+1..t+2; one load per 3 cycles. Backpressure: hold blocks new grants only.
// Ports: clk/rst (sync, active-high); req/sel/din per-requester inputs, sampled in IDLE;
//        hold gates new grants; bus_d/e_/gnt/ack/err registered outputs; busy = not IDLE.
module regload_arbiter
  import regload_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int NREG  = 4,
  parameter int SELW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*SELW-1:0]  sel,
  input  logic [NREQ*WIDTH-1:0] din,
  input  logic                  hold,
  output logic [WIDTH-1:0]      bus_d,
  output logic [NREG-1:0]       e_,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic                  busy
);

  localparam int PW = clog2(NREQ);
  localparam logic [SELW:0] NREG_L = (SELW+1)'(NREG);

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [WIDTH-1:0] bus_d_q, bus_d_d;
  logic [NREG-1:0]  e_q, e_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             err_q, err_d;

  logic [PW-1:0]    pick_win;
  logic             pick_vld;
  logic [SELW-1:0]  pick_sel;
  logic [WIDTH-1:0] pick_din;
  logic             pick_in_range;
  logic             sel_q_in_range;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .vld_o (pick_vld)
  );

  assign pick_sel       = sel[int'(pick_win)*SELW +: SELW];
  assign pick_din       = din[int'(pick_win)*WIDTH +: WIDTH];
  assign pick_in_range  = ({1'b0, pick_sel} < NREG_L);
  assign sel_q_in_range = ({1'b0, sel_q} < NREG_L);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    sel_d   = sel_q;
    bus_d_d = bus_d_q;
    e_d     = e_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (!hold && pick_vld) begin
          state_d = S_LOAD;
          win_d   = pick_win;
          sel_d   = pick_sel;
          bus_d_d = pick_din;
          gnt_d   = '0;
          gnt_d[pick_win] = 1'b1;
          // An out-of-range select still runs the full cycle but loads nothing.
          e_d = '1;
          if (pick_in_range) begin
            e_d[pick_sel] = 1'b0;
          end
        end
      end
      S_LOAD: begin
        // The register bank captures bus_d on this edge; bus_d keeps its value.
        state_d = S_ACK;
        e_d     = '1;
        gnt_d   = '0;
        ack_d   = gnt_q;
        err_d   = !sel_q_in_range;
      end
      S_ACK: begin
        state_d = S_IDLE;
        ack_d   = '0;
        err_d   = 1'b0;
        ptr_d   = (win_q == PW'(NREQ-1)) ? '0 : win_q + PW'(1);
      end
      default: begin
        state_d = S_IDLE;
        e_d     = '1;
        gnt_d   = '0;
        ack_d   = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      sel_q   <= '0;
      bus_d_q <= '0;
      e_q     <= '1;
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      bus_d_q <= bus_d_d;
      e_q     <= e_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign bus_d = bus_d_q;
  assign e_    = e_q;
  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_regload_arbiter.sv
module tb_regload_arbiter;

  typedef struct {
    int         w;
    int         r;
    logic [7:0] d;
    logic       e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  // Instance A: 4 target registers
  logic [3:0]  req;
  logic [7:0]  sel;
  logic [31:0] din;
  logic        hold;
  logic [7:0]  bus_d;
  logic [3:0]  e_;
  logic [3:0]  gnt, ack;
  logic        err, busy;
  // Instance B: 3 target registers (out-of-range select)
  logic [3:0]  b_req;
  logic [7:0]  b_sel;
  logic [31:0] b_din;
  logic        b_hold;
  logic [7:0]  b_bus_d;
  logic [2:0]  b_e_;
  logic [3:0]  b_gnt, b_ack;
  logic        b_err, b_busy;

  int   checks = 0;
  int   errors = 0;
  bit   inv_en = 1'b0;
  exp_t sbq[$];

  logic [7:0] regm [4] = '{default: 8'h00};
  logic [7:0] regb [3] = '{default: 8'h00};

  regload_arbiter #(.WIDTH(8), .NREQ(4), .NREG(4), .SELW(2)) dut_a (
    .clk(clk), .rst(rst), .req(req), .sel(sel), .din(din), .hold(hold),
    .bus_d(bus_d), .e_(e_), .gnt(gnt), .ack(ack), .err(err), .busy(busy)
  );

  regload_arbiter #(.WIDTH(8), .NREQ(4), .NREG(3), .SELW(2)) dut_b (
    .clk(clk), .rst(rst), .req(b_req), .sel(b_sel), .din(b_din), .hold(b_hold),
    .bus_d(b_bus_d), .e_(b_e_), .gnt(b_gnt), .ack(b_ack), .err(b_err), .busy(b_busy)
  );

  always #5 clk = ~clk;

  // Downstream register banks: load on the rising edge while e_ is low.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) if (e_[k] === 1'b0) regm[k] <= bus_d;
    for (int k = 0; k < 3; k++) if (b_e_[k] === 1'b0) regb[k] <= b_bus_d;
  end

  // Structural invariants on instance A, sampled mid-cycle.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if ($countones(~e_) > 1 || (ack !== 4'b0 && (gnt !== 4'b0 || e_ !== 4'hF))) begin
        errors++;
        $display("FAIL invariant: e_=%b gnt=%b ack=%b", e_, gnt, ack);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; sel = '0; din = '0; hold = 1'b0;
    b_req = '0; b_sel = '0; b_din = '0; b_hold = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic int model_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    req = 4'hF; sel = 8'hE4; din = 32'h44332211; hold = 1'b0;
    b_req = 4'hF; b_sel = 8'hE4; b_din = 32'h44332211; b_hold = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (e_ !== 4'hF) begin errors++; $display("FAIL reset_e_: got %b want 1111", e_); end
      checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      checks++; if (ack !== 4'h0) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
      checks++; if (bus_d !== 8'h00) begin errors++; $display("FAIL reset_bus_d: got %h want 00", bus_d); end
      checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_busy_err: got %b%b want 00", busy, err); end
      checks++; if (b_e_ !== 3'b111 || b_gnt !== 4'h0) begin errors++; $display("FAIL reset_b: got e_=%b gnt=%b", b_e_, b_gnt); end
    end
    req = '0; b_req = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_load();
    exp_t e;
    do_reset();
    sel = 8'h02; din = 32'h000000A5; req = 4'b0001;
    sbq.push_back('{w: 0, r: 2, d: 8'hA5, e: 1'b0});
    tick();
    checks++; if (e_ !== 4'b1011) begin errors++; $display("FAIL single_e_: got %b want 1011", e_); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    checks++; if (bus_d !== 8'hA5) begin errors++; $display("FAIL single_bus_d: got %h want a5", bus_d); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    tick();
    req = '0;
    e = sbq.pop_front();
    checks++; if (e_ !== 4'hF) begin errors++; $display("FAIL single_e_off: got %b want 1111", e_); end
    checks++; if (ack !== (4'b0001 << e.w) || err !== e.e) begin errors++; $display("FAIL single_ack: got ack=%b err=%b want %b %b", ack, err, 4'b0001 << e.w, e.e); end
    checks++; if (regm[e.r] !== e.d) begin errors++; $display("FAIL single_reg: got %h want %h", regm[e.r], e.d); end
    tick();
    checks++; if (ack !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got ack=%b busy=%b want 0000 0", ack, busy); end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int p, w, last, nack;
    logic [7:0] dv [4];
    do_reset();
    dv = '{8'h11, 8'h22, 8'h33, 8'h44};
    sel = {2'd3, 2'd2, 2'd1, 2'd0};
    din = {dv[3], dv[2], dv[1], dv[0]};
    p = 0;
    for (int n = 0; n < 5; n++) begin
      w = model_pick(4'hF, p);
      sbq.push_back('{w: w, r: w, d: dv[w], e: 1'b0});
      p = (w + 1) % 4;
    end
    req = 4'hF;
    last = -1; nack = 0;
    for (int cyc = 0; cyc < 40 && nack < 5; cyc++) begin
      tick();
      if (gnt !== 4'h0 && sbq.size() > 0) begin
        checks++; if (gnt !== (4'b0001 << sbq[0].w)) begin errors++; $display("FAIL rr_gnt: got %b want %b", gnt, 4'b0001 << sbq[0].w); end
        if (last >= 0) begin
          checks++; if (cyc - last != 3) begin errors++; $display("FAIL rr_spacing: got %0d want 3", cyc - last); end
        end
        last = cyc;
      end
      if (ack !== 4'h0 && sbq.size() > 0) begin
        e = sbq.pop_front();
        nack++;
        checks++; if (ack !== (4'b0001 << e.w)) begin errors++; $display("FAIL rr_ack: got %b want %b", ack, 4'b0001 << e.w); end
        checks++; if (regm[e.r] !== e.d) begin errors++; $display("FAIL rr_reg: got %h want %h", regm[e.r], e.d); end
      end
    end
    checks++; if (nack != 5) begin errors++; $display("FAIL rr_timeout: got %0d acks want 5", nack); end
    sbq.delete();
    req = '0;
    tick(); tick();
  endtask

  task automatic test_out_of_range();
    exp_t e;
    int nack;
    logic [7:0] snap [3];
    do_reset();
    snap = regb;
    b_sel = 8'h03; b_din = 32'h0000005A; b_req = 4'b0001;
    sbq.push_back('{w: 0, r: -1, d: 8'h5A, e: 1'b1});
    nack = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      checks++; if (b_e_ !== 3'b111) begin errors++; $display("FAIL oor_e_: got %b want 111", b_e_); end
      if (b_ack !== 4'h0 && sbq.size() > 0) begin
        e = sbq.pop_front();
        nack++;
        b_req = '0;
        checks++; if (b_ack !== (4'b0001 << e.w) || b_err !== e.e) begin errors++; $display("FAIL oor_ack_err: got ack=%b err=%b want %b %b", b_ack, b_err, 4'b0001 << e.w, e.e); end
      end
    end
    checks++; if (nack != 1) begin errors++; $display("FAIL oor_timeout: got %0d acks want 1", nack); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (regb[k] !== snap[k]) begin errors++; $display("FAIL oor_reg%0d: got %h want %h", k, regb[k], snap[k]); end
    end
    sbq.delete();
    b_req = '0;
  endtask

  task automatic test_hold();
    exp_t e;
    do_reset();
    hold = 1'b1;
    sel = 8'h10; din = 32'h00C30000; req = 4'b0100;
    sbq.push_back('{w: model_pick(4'b0100, 0), r: 1, d: 8'hC3, e: 1'b0});
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (gnt !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL hold_blocked: got gnt=%b busy=%b want 0000 0", gnt, busy); end
    end
    hold = 1'b0;
    tick();
    checks++; if (gnt !== (4'b0001 << sbq[0].w)) begin errors++; $display("FAIL hold_release_gnt: got %b want %b", gnt, 4'b0001 << sbq[0].w); end
    hold = 1'b1;
    tick();
    e = sbq.pop_front();
    req = '0;
    checks++; if (ack !== (4'b0001 << e.w) || err !== e.e) begin errors++; $display("FAIL hold_ack: got ack=%b err=%b want %b %b", ack, err, 4'b0001 << e.w, e.e); end
    checks++; if (regm[e.r] !== e.d) begin errors++; $display("FAIL hold_reg: got %h want %h", regm[e.r], e.d); end
    hold = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_done_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    sel = 8'h30; din = 32'h00EE0000; req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mid_gnt: got %b want 0100", gnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL mid_no_ack: got %b want 0000", ack); end
    checks++; if (e_ !== 4'hF || gnt !== 4'h0) begin errors++; $display("FAIL mid_outputs: got e_=%b gnt=%b want 1111 0000", e_, gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    req = 4'b0101; sel = 8'h00; din = 32'h00EE0077;
    sbq.push_back('{w: model_pick(4'b0101, 0), r: 0, d: 8'h77, e: 1'b0});
    tick();
    checks++; if (gnt !== (4'b0001 << sbq[0].w)) begin errors++; $display("FAIL mid_ptr_gnt: got %b want %b", gnt, 4'b0001 << sbq[0].w); end
    tick();
    e = sbq.pop_front();
    req = '0;
    checks++; if (ack !== (4'b0001 << e.w)) begin errors++; $display("FAIL mid_ack: got %b want %b", ack, 4'b0001 << e.w); end
    checks++; if (regm[e.r] !== e.d) begin errors++; $display("FAIL mid_reg: got %h want %h", regm[e.r], e.d); end
    tick();
  endtask

  initial begin
    test_reset();
    inv_en = 1'b1;
    test_single_load();
    test_round_robin();
    test_out_of_range();
    test_hold();
    test_reset_mid();
    inv_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
